// File: rtl/sparse_entry_packer.sv
// Packs a dense row-major DIM x DIM byte stream into (row, col, value) triples of its non-zero elements.
// Optional feature macro: NNZ_COUNT_EN adds the nnz_count output (number of triples pushed this load).
module sparse_entry_packer #(
   parameter  int DIM        = 4,
   parameter  int DATA_W     = 8,
   parameter  int FIFO_DEPTH = 4,
   localparam int IDX_W      = (DIM > 1) ? $clog2(DIM) : 1,
   localparam int NNZ_W      = $clog2(DIM * DIM) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [IDX_W-1:0]  out_row,
   output logic [IDX_W-1:0]  out_col,
   output logic [DATA_W-1:0] out_value,
   output logic              sending_CPU,
   input  logic              FETCH_ready,
   output logic              done_list,
`ifdef NNZ_COUNT_EN
   output logic [NNZ_W-1:0]  nnz_count,
`endif
   output logic              busy
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int PTR_W = AW + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic [IDX_W-1:0]  row;
      logic [IDX_W-1:0]  col;
      logic [DATA_W-1:0] value;
   } entry_t;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] row_q, row_d;
   logic [IDX_W-1:0] col_q, col_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   entry_t           mem_q [FIFO_DEPTH];

   logic   fifo_empty;
   logic   fifo_full;
   logic   accept;
   logic   push;
   logic   pop;
   logic   last_elem;
   entry_t head;

   // Extra pointer MSB tells a full FIFO apart from an empty one.
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q == {~rd_ptr_q[AW], rd_ptr_q[AW-1:0]});
   assign last_elem  = (row_q == LAST_IDX) && (col_q == LAST_IDX);
   assign head       = mem_q[rd_ptr_q[AW-1:0]];

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start)                state_d = LOAD;
         LOAD:    if (accept && last_elem)  state_d = DRAIN;
         DRAIN:   if (fifo_empty)           state_d = DONE;
         DONE:    if (FETCH_ready)          state_d = IDLE;
         default:                           state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready    = (state_q == LOAD) && !fifo_full;
      sending_CPU = (state_q != DONE) && !fifo_empty;
      done_list   = (state_q == DONE);
      busy        = (state_q != IDLE);
      accept      = in_valid && in_ready;
      push        = accept && (in_data != '0);
      pop         = sending_CPU && FETCH_ready;
   end

   // Head fields read as zero whenever nothing is buffered, so reset leaves them at 0.
   always_comb begin
      out_row   = fifo_empty ? '0 : head.row;
      out_col   = fifo_empty ? '0 : head.col;
      out_value = fifo_empty ? '0 : head.value;
   end

   // ---------------- Datapath next state ----------------
   always_comb begin
      row_d    = row_q;
      col_d    = col_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if ((state_q == IDLE) && start) begin
         row_d = '0;
         col_d = '0;
      end else if (accept) begin
         if (col_q == LAST_IDX) begin
            col_d = '0;
            row_d = row_q + IDX_W'(1);
         end else begin
            col_d = col_q + IDX_W'(1);
         end
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values, regardless of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_q    <= '0;
         col_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         row_q    <= row_d;
         col_q    <= col_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: storage is not reset; equal pointers mark it empty and the head is masked, so stale data never escapes.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{row: row_q, col: col_q, value: in_data};
   end

`ifdef NNZ_COUNT_EN
   logic [NNZ_W-1:0] nnz_q, nnz_d;

   always_comb begin
      nnz_d = nnz_q;
      if ((state_q == IDLE) && start) nnz_d = '0;
      else if (push)                  nnz_d = nnz_q + NNZ_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) nnz_q <= '0;
      else     nnz_q <= nnz_d;
   end

   assign nnz_count = nnz_q;
`endif

endmodule

// File: tb/tb_sparse_entry_packer.sv
// Directed self-checking bench for sparse_entry_packer; triples are collected by a negedge monitor.
// Build with NNZ_COUNT_EN defined to also exercise nnz_count.
module tb_sparse_entry_packer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [1:0] out_row;
   logic [1:0] out_col;
   logic [7:0] out_value;
   logic       sending_CPU;
   logic       FETCH_ready;
   logic       done_list;
   logic       busy;
`ifdef NNZ_COUNT_EN
   logic [4:0] nnz_count;
`endif

   int n_total = 0;
   int n_bad   = 0;
   int n_done  = 0;
   logic [11:0] got_q [$];

   sparse_entry_packer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_row    (out_row),
      .out_col    (out_col),
      .out_value  (out_value),
      .sending_CPU(sending_CPU),
      .FETCH_ready(FETCH_ready),
      .done_list  (done_list),
`ifdef NNZ_COUNT_EN
      .nnz_count  (nnz_count),
`endif
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Inputs change at posedge+1, so negedge sees what the next edge will act on.
   always @(negedge clk) begin
      if (sending_CPU && FETCH_ready) got_q.push_back({out_row, out_col, out_value});
      if (done_list && FETCH_ready)   n_done++;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   function automatic logic [11:0] mk(input int r, input int c, input logic [7:0] v);
      logic [1:0] rr, cc;
      rr = 2'(r);
      cc = 2'(c);
      return {rr, cc, v};
   endfunction

   task automatic feed(input string tag, input logic [7:0] d);
      int k;
      k = 0;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      while (!in_ready && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) check({tag, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int k;
      for (k = 0; k < 60; k++) begin
         if (done_list) break;
         tick();
      end
      if (!done_list) check({tag, "_done_timeout"}, 32'(done_list), 32'd1);
   endtask

   task automatic compare_list(input string tag, input logic [11:0] exp_q [$]);
      check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         check($sformatf("%s_triple%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      logic [11:0] exp_q [$];
      logic [7:0]  mat [16];
      int          d0, k;

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; FETCH_ready = 1'b0;
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_sending", 32'(sending_CPU), 0);
      check("rst_done", 32'(done_list), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_head", 32'({out_row, out_col, out_value}), 0);
`ifdef NNZ_COUNT_EN
      check("rst_nnz", 32'(nnz_count), 0);
`endif
      rst = 1'b0;
      tick();

      // Dense: 1..16 with the consumer always ready.
      got_q.delete(); exp_q.delete(); d0 = n_done;
      FETCH_ready = 1'b1;
      pulse_start();
      check("dense_busy", 32'(busy), 1);
      feed("dense", 8'd1);
      check("dense_latency_valid", 32'(sending_CPU), 1);
      check("dense_latency_head", 32'({out_row, out_col, out_value}), 32'(mk(0, 0, 8'd1)));
      for (int i = 1; i < 16; i++) feed("dense", 8'(i + 1));
      for (int i = 0; i < 16; i++) exp_q.push_back(mk(i / 4, i % 4, 8'(i + 1)));
      wait_done("dense");
      tick();
      check("dense_done_one_cycle", 32'(done_list), 0);
      check("dense_idle", 32'(busy), 0);
      check("dense_done_acks", 32'(n_done - d0), 1);
      compare_list("dense", exp_q);
`ifdef NNZ_COUNT_EN
      check("dense_nnz", 32'(nnz_count), 16);
`endif

      // Sparse: only element 6 and element 15 non-zero.
      got_q.delete(); exp_q.delete(); d0 = n_done;
      pulse_start();
      for (int i = 0; i < 16; i++) feed("sparse", (i == 6) ? 8'h5A : (i == 15) ? 8'h07 : 8'h00);
      exp_q.push_back(mk(1, 2, 8'h5A));
      exp_q.push_back(mk(3, 3, 8'h07));
      wait_done("sparse");
      tick();
      check("sparse_done_acks", 32'(n_done - d0), 1);
      compare_list("sparse", exp_q);
`ifdef NNZ_COUNT_EN
      check("sparse_nnz", 32'(nnz_count), 2);
`endif

      // All-zero matrix: no triples, done_list within 2 cycles of the last accept.
      got_q.delete(); exp_q.delete(); d0 = n_done;
      pulse_start();
      for (int i = 0; i < 16; i++) feed("zero", 8'h00);
      k = 0;
      while (!done_list && k < 10) begin
         tick();
         k++;
      end
      check("zero_done_within_2", 32'(done_list && (k <= 1)), 1);
      tick();
      check("zero_done_acks", 32'(n_done - d0), 1);
      compare_list("zero", exp_q);
`ifdef NNZ_COUNT_EN
      check("zero_nnz", 32'(nnz_count), 0);
`endif

      // Backpressure: consumer stalled until the FIFO fills, then released.
      got_q.delete(); exp_q.delete(); d0 = n_done;
      FETCH_ready = 1'b0;
      for (int i = 0; i < 16; i++) mat[i] = 8'(8'h21 + i);
      pulse_start();
      for (int i = 0; i < 4; i++) feed("bp", mat[i]);
      check("bp_full_in_ready", 32'(in_ready), 0);
      check("bp_head", 32'({sending_CPU, out_row, out_col, out_value}), 32'({1'b1, mk(0, 0, 8'h21)}));
      in_valid = 1'b1;
      in_data  = mat[4];
      tick(); tick(); tick();
      check("bp_hold_in_ready", 32'(in_ready), 0);
      check("bp_hold_head", 32'({sending_CPU, out_row, out_col, out_value}), 32'({1'b1, mk(0, 0, 8'h21)}));
      FETCH_ready = 1'b1;
      for (int i = 4; i < 16; i++) feed("bp", mat[i]);
      for (int i = 0; i < 16; i++) exp_q.push_back(mk(i / 4, i % 4, mat[i]));
      wait_done("bp");
      tick();
      check("bp_done_acks", 32'(n_done - d0), 1);
      compare_list("bp", exp_q);

      // Mid-load reset after 7 accepts with 3 triples buffered, then a clean reload.
      got_q.delete(); exp_q.delete(); d0 = n_done;
      FETCH_ready = 1'b0;
      mat[0] = 8'h00; mat[1] = 8'h05; mat[2] = 8'h00; mat[3] = 8'h00;
      mat[4] = 8'h09; mat[5] = 8'h00; mat[6] = 8'h03;
      pulse_start();
      for (int i = 0; i < 7; i++) feed("mid", mat[i]);
      check("mid_pre_head", 32'({sending_CPU, in_ready, out_row, out_col, out_value}),
            32'({2'b11, mk(0, 1, 8'h05)}));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_sending", 32'(sending_CPU), 0);
      check("mid_rst_in_ready", 32'(in_ready), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_done", 32'(done_list), 0);
      tick();
      check("mid_no_partial_done", 32'(n_done - d0), 0);
      FETCH_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 16; i++) feed("mid2", 8'(8'h80 + i));
      for (int i = 0; i < 16; i++) exp_q.push_back(mk(i / 4, i % 4, 8'(8'h80 + i)));
      wait_done("mid2");
      tick();
      check("mid2_done_acks", 32'(n_done - d0), 1);
      compare_list("mid2", exp_q);
`ifdef NNZ_COUNT_EN
      check("mid2_nnz", 32'(nnz_count), 16);
`endif

      // Stray start during DRAIN and during DONE.
      got_q.delete(); exp_q.delete(); d0 = n_done;
      FETCH_ready = 1'b0;
      pulse_start();
      for (int i = 0; i < 16; i++) feed("stray", (i == 14) ? 8'h33 : (i == 15) ? 8'h44 : 8'h00);
      pulse_start();
      check("stray_drain_state", 32'({busy, in_ready, sending_CPU, done_list}), 32'(4'b1010));
      FETCH_ready = 1'b1;
      tick();
      tick();
      FETCH_ready = 1'b0;
      tick();
      check("stray_done_entered", 32'({done_list, sending_CPU}), 32'(2'b10));
      pulse_start();
      tick();
      check("stray_done_held", 32'({busy, done_list, in_ready}), 32'(3'b110));
      FETCH_ready = 1'b1;
      tick();
      FETCH_ready = 1'b0;
      check("stray_idle", 32'({busy, done_list}), 0);
      check("stray_done_acks", 32'(n_done - d0), 1);
      exp_q.push_back(mk(3, 2, 8'h33));
      exp_q.push_back(mk(3, 3, 8'h44));
      compare_list("stray", exp_q);
`ifdef NNZ_COUNT_EN
      check("stray_nnz", 32'(nnz_count), 2);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
